// File: rtl/rat_multiport.sv
// +------------------------------------------------------------------------------+
// | rat_multiport: multi-port register alias table with branch checkpoints.     |
// | Optional macro RAT_MULTIPORT_COMMIT_RAT_EN adds a committed RAT for flush.  |
// | Revision: 1.0                                                                |
// +------------------------------------------------------------------------------+
`default_nettype none

module rat_multiport #(
  parameter int N_ARCH_REGS  = 32,
  parameter int N_PHYS_REGS  = 128,
  parameter int RENAME_WIDTH = 2,
  parameter int N_CKPT       = 4,
  localparam int PW = $clog2(N_PHYS_REGS),
  localparam int AW = $clog2(N_ARCH_REGS),
  localparam int RW = RENAME_WIDTH,
  localparam int CW = $clog2(N_CKPT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             recover_i,
  input  logic [CW-1:0]    recover_ckpt_i,
  input  logic [RW-1:0]    ren_valid_i,
  input  logic [RW*AW-1:0] ren_rs1_i,
  input  logic [RW*AW-1:0] ren_rs2_i,
  input  logic [RW*AW-1:0] ren_rd_i,
  input  logic [RW*PW-1:0] ren_new_phys_i,
  input  logic [RW-1:0]    ren_ckpt_req_i,
  output logic [RW*PW-1:0] ren_rs1_phys_o,
  output logic [RW*PW-1:0] ren_rs2_phys_o,
  output logic [RW*PW-1:0] ren_rd_old_phys_o,
  output logic [RW*CW-1:0] ren_ckpt_id_o,
  output logic             stall_o,
  input  logic             ckpt_release_i,
  output logic [CW:0]      ckpt_free_o,
  input  logic [RW-1:0]    cmt_valid_i,
  input  logic [RW*AW-1:0] cmt_rd_i,
  input  logic [RW*PW-1:0] cmt_phys_i
);

  localparam logic [CW:0] FULL = (CW+1)'(N_CKPT);

  logic [PW-1:0] rat      [N_ARCH_REGS];
  logic [PW-1:0] stage    [RW+1][N_ARCH_REGS];
  logic [PW-1:0] ckpt_mem [N_CKPT][N_ARCH_REGS];
  logic [CW-1:0] head, tail;
  logic [CW:0]   free_cnt;
  logic [CW-1:0] slot_id [RW];
  logic [31:0]   req_cnt;
  logic [CW-1:0] rec_occ;
  logic          accept, release_ok, rec_pop;

  // stage[k] is the map seen by slot k: RAT plus writes of slots 0..k-1
  always_comb begin
    for (int k = 0; k <= RW; k++) begin
      for (int i = 0; i < N_ARCH_REGS; i++) begin
        stage[k][i] = rat[i];
        for (int j = 0; j < k; j++) begin
          if (ren_valid_i[j] && i != 0 && ren_rd_i[j*AW +: AW] == AW'(i))
            stage[k][i] = ren_new_phys_i[j*PW +: PW];
        end
      end
    end
  end

  always_comb begin
    req_cnt           = '0;
    ren_rs1_phys_o    = '0;
    ren_rs2_phys_o    = '0;
    ren_rd_old_phys_o = '0;
    ren_ckpt_id_o     = '0;
    for (int k = 0; k < RW; k++) begin
      slot_id[k] = tail + CW'(req_cnt);
      if (ren_valid_i[k] && ren_ckpt_req_i[k])
        req_cnt = req_cnt + 32'd1;
      ren_rs1_phys_o[k*PW +: PW]    = stage[k][ren_rs1_i[k*AW +: AW]];
      ren_rs2_phys_o[k*PW +: PW]    = stage[k][ren_rs2_i[k*AW +: AW]];
      ren_rd_old_phys_o[k*PW +: PW] = stage[k][ren_rd_i[k*AW +: AW]];
      ren_ckpt_id_o[k*CW +: CW]     = slot_id[k];
    end
  end

  assign stall_o     = req_cnt > 32'(free_cnt);
  assign ckpt_free_o = free_cnt;
  assign accept      = (|ren_valid_i) && !stall_o && !recover_i && !flush_i;
  assign release_ok  = ckpt_release_i && (free_cnt != FULL);
  // Recovering to a slot frees it and everything younger; a concurrent release
  // pops the head only when the head survives the recovery.
  assign rec_occ     = recover_ckpt_i - head;
  assign rec_pop     = ckpt_release_i && (head != recover_ckpt_i);

`ifdef RAT_MULTIPORT_COMMIT_RAT_EN
  logic [PW-1:0] cmt_rat  [N_ARCH_REGS];
  logic [PW-1:0] cmt_next [N_ARCH_REGS];

  always_comb begin
    cmt_next = cmt_rat;
    for (int j = 0; j < RW; j++) begin
      if (cmt_valid_i[j] && cmt_rd_i[j*AW +: AW] != '0)
        cmt_next[cmt_rd_i[j*AW +: AW]] = cmt_phys_i[j*PW +: PW];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_ARCH_REGS; i++) cmt_rat[i] <= PW'(i);
    end else begin
      cmt_rat <= cmt_next;
    end
  end
`else
  logic unused_cmt;
  assign unused_cmt = ^{cmt_valid_i, cmt_rd_i, cmt_phys_i};
`endif

  always_ff @(posedge clk) begin
    for (int k = 0; k < RW; k++) begin
      if (accept && ren_valid_i[k] && ren_ckpt_req_i[k])
        ckpt_mem[slot_id[k]] <= stage[k+1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_ARCH_REGS; i++) rat[i] <= PW'(i);
      head     <= '0;
      tail     <= '0;
      free_cnt <= FULL;
    end else if (recover_i) begin
      rat      <= ckpt_mem[recover_ckpt_i];
      tail     <= recover_ckpt_i;
      head     <= head + CW'(rec_pop);
      free_cnt <= FULL - {1'b0, rec_occ} + (CW+1)'(rec_pop);
    end else if (flush_i) begin
      head     <= tail;
      free_cnt <= FULL;
`ifdef RAT_MULTIPORT_COMMIT_RAT_EN
      rat      <= cmt_next;
`endif
    end else begin
      if (accept) begin
        rat  <= stage[RW];
        tail <= tail + CW'(req_cnt);
      end
      head     <= head + CW'(release_ok);
      free_cnt <= free_cnt + (CW+1)'(release_ok) - (accept ? (CW+1)'(req_cnt) : '0);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rat_multiport.sv
// +------------------------------------------------------------------------------+
// | tb_rat_multiport: scoreboard bench for rat_multiport (default parameters).   |
// | Revision: 1.0                                                                |
// +------------------------------------------------------------------------------+
`default_nettype none

module tb_rat_multiport;
  localparam int PW = 7, AW = 5, RW = 2, CW = 2;

  logic clk = 1'b0;
  logic rst_n, flush_i, recover_i, ckpt_release_i, stall_o;
  logic [CW-1:0] recover_ckpt_i;
  logic [RW-1:0] ren_valid_i, ren_ckpt_req_i, cmt_valid_i;
  logic [RW*AW-1:0] ren_rs1_i, ren_rs2_i, ren_rd_i, cmt_rd_i;
  logic [RW*PW-1:0] ren_new_phys_i, cmt_phys_i;
  logic [RW*PW-1:0] ren_rs1_phys_o, ren_rs2_phys_o, ren_rd_old_phys_o;
  logic [RW*CW-1:0] ren_ckpt_id_o;
  logic [CW:0] ckpt_free_o;

  int total = 0;
  int bad = 0;
  int sb[$];

  rat_multiport dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .recover_i(recover_i),
    .recover_ckpt_i(recover_ckpt_i), .ren_valid_i(ren_valid_i), .ren_rs1_i(ren_rs1_i),
    .ren_rs2_i(ren_rs2_i), .ren_rd_i(ren_rd_i), .ren_new_phys_i(ren_new_phys_i),
    .ren_ckpt_req_i(ren_ckpt_req_i), .ren_rs1_phys_o(ren_rs1_phys_o),
    .ren_rs2_phys_o(ren_rs2_phys_o), .ren_rd_old_phys_o(ren_rd_old_phys_o),
    .ren_ckpt_id_o(ren_ckpt_id_o), .stall_o(stall_o), .ckpt_release_i(ckpt_release_i),
    .ckpt_free_o(ckpt_free_o), .cmt_valid_i(cmt_valid_i), .cmt_rd_i(cmt_rd_i),
    .cmt_phys_i(cmt_phys_i)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rs1p(input int k); return 32'(ren_rs1_phys_o[k*PW +: PW]); endfunction
  function automatic logic [31:0] rs2p(input int k); return 32'(ren_rs2_phys_o[k*PW +: PW]); endfunction
  function automatic logic [31:0] rdo(input int k);  return 32'(ren_rd_old_phys_o[k*PW +: PW]); endfunction
  function automatic logic [31:0] cid(input int k);  return 32'(ren_ckpt_id_o[k*CW +: CW]); endfunction

  task automatic clear;
    flush_i = 0; recover_i = 0; recover_ckpt_i = '0; ckpt_release_i = 0;
    ren_valid_i = '0; ren_ckpt_req_i = '0; ren_rs1_i = '0; ren_rs2_i = '0;
    ren_rd_i = '0; ren_new_phys_i = '0; cmt_valid_i = '0; cmt_rd_i = '0; cmt_phys_i = '0;
  endtask

  // inputs change 2 time units after the rising edge, outputs sampled 1 unit later
  task automatic step;
    @(posedge clk); #2;
  endtask

  task automatic set_slot(input int k, input int rs1, input int rs2, input int rd, input int np, input bit ck);
    ren_valid_i[k] = 1'b1; ren_ckpt_req_i[k] = ck;
    ren_rs1_i[k*AW +: AW] = AW'(rs1); ren_rs2_i[k*AW +: AW] = AW'(rs2);
    ren_rd_i[k*AW +: AW] = AW'(rd); ren_new_phys_i[k*PW +: PW] = PW'(np);
  endtask

  task automatic look(input int k, input int rs1, input int rs2);
    ren_rs1_i[k*AW +: AW] = AW'(rs1); ren_rs2_i[k*AW +: AW] = AW'(rs2);
  endtask

  task automatic test_reset;
    int e;
    clear; rst_n = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    look(0, 5, 31);
    sb.push_back(5); sb.push_back(31); sb.push_back(4); sb.push_back(0);
    #1;
    e = sb.pop_front(); total++; if (rs1p(0) !== e) begin bad++; $display("FAIL reset_rs1 got=%0d exp=%0d", rs1p(0), e); end
    e = sb.pop_front(); total++; if (rs2p(0) !== e) begin bad++; $display("FAIL reset_rs2 got=%0d exp=%0d", rs2p(0), e); end
    e = sb.pop_front(); total++; if (32'(ckpt_free_o) !== e) begin bad++; $display("FAIL reset_free got=%0d exp=%0d", ckpt_free_o, e); end
    e = sb.pop_front(); total++; if (32'(stall_o) !== e) begin bad++; $display("FAIL reset_stall got=%0d exp=%0d", stall_o, e); end
    // group in flight while reset is held must be discarded
    set_slot(0, 0, 0, 5, 99, 1);
    #1 rst_n = 0;
    step;
    clear; rst_n = 1;
    look(0, 5, 0);
    sb.push_back(5); sb.push_back(4);
    #1;
    e = sb.pop_front(); total++; if (rs1p(0) !== e) begin bad++; $display("FAIL reset_discard got=%0d exp=%0d", rs1p(0), e); end
    e = sb.pop_front(); total++; if (32'(ckpt_free_o) !== e) begin bad++; $display("FAIL reset_discard_free got=%0d exp=%0d", ckpt_free_o, e); end
  endtask

  task automatic test_bypass;
    int e;
    step; clear;
    set_slot(0, 0, 0, 3, 40, 0);
    set_slot(1, 3, 0, 3, 41, 0);
    sb.push_back(3); sb.push_back(40); sb.push_back(40); sb.push_back(0);
    #1;
    e = sb.pop_front(); total++; if (rdo(0) !== e) begin bad++; $display("FAIL byp_rdold0 got=%0d exp=%0d", rdo(0), e); end
    e = sb.pop_front(); total++; if (rs1p(1) !== e) begin bad++; $display("FAIL byp_rs1_1 got=%0d exp=%0d", rs1p(1), e); end
    e = sb.pop_front(); total++; if (rdo(1) !== e) begin bad++; $display("FAIL byp_rdold1 got=%0d exp=%0d", rdo(1), e); end
    e = sb.pop_front(); total++; if (rs2p(1) !== e) begin bad++; $display("FAIL byp_r0 got=%0d exp=%0d", rs2p(1), e); end
    step; clear;
    look(0, 3, 0);
    sb.push_back(41);
    #1;
    e = sb.pop_front(); total++; if (rs1p(0) !== e) begin bad++; $display("FAIL byp_commit got=%0d exp=%0d", rs1p(0), e); end
  endtask

  task automatic test_ckpt_recover;
    int e;
    step; clear;
    set_slot(0, 0, 0, 7, 50, 1);
    set_slot(1, 0, 0, 7, 51, 0);
    sb.push_back(0); sb.push_back(0);
    #1;
    e = sb.pop_front(); total++; if (cid(0) !== e) begin bad++; $display("FAIL ck_id got=%0d exp=%0d", cid(0), e); end
    e = sb.pop_front(); total++; if (32'(stall_o) !== e) begin bad++; $display("FAIL ck_stall got=%0d exp=%0d", stall_o, e); end
    step; clear;
    look(0, 7, 0);
    sb.push_back(51); sb.push_back(3);
    #1;
    e = sb.pop_front(); total++; if (rs1p(0) !== e) begin bad++; $display("FAIL ck_after got=%0d exp=%0d", rs1p(0), e); end
    e = sb.pop_front(); total++; if (32'(ckpt_free_o) !== e) begin bad++; $display("FAIL ck_free got=%0d exp=%0d", ckpt_free_o, e); end
    recover_i = 1; recover_ckpt_i = 2'd0;
    step; clear;
    look(0, 7, 3);
    sb.push_back(50); sb.push_back(41); sb.push_back(4);
    #1;
    e = sb.pop_front(); total++; if (rs1p(0) !== e) begin bad++; $display("FAIL rec_r7 got=%0d exp=%0d", rs1p(0), e); end
    e = sb.pop_front(); total++; if (rs2p(0) !== e) begin bad++; $display("FAIL rec_r3 got=%0d exp=%0d", rs2p(0), e); end
    e = sb.pop_front(); total++; if (32'(ckpt_free_o) !== e) begin bad++; $display("FAIL rec_free got=%0d exp=%0d", ckpt_free_o, e); end
  endtask

  task automatic test_stall;
    int e;
    for (int c = 0; c < 3; c++) begin
      step; clear;
      set_slot(0, 0, 0, 10 + c, 70 + c, 1);
      sb.push_back(c);
      #1;
      e = sb.pop_front(); total++; if (cid(0) !== e) begin bad++; $display("FAIL st_fill_id%0d got=%0d exp=%0d", c, cid(0), e); end
    end
    step; clear;
    set_slot(0, 0, 0, 20, 80, 1);
    set_slot(1, 0, 0, 21, 81, 1);
    sb.push_back(1); sb.push_back(1);
    #1;
    e = sb.pop_front(); total++; if (32'(ckpt_free_o) !== e) begin bad++; $display("FAIL st_free1 got=%0d exp=%0d", ckpt_free_o, e); end
    e = sb.pop_front(); total++; if (32'(stall_o) !== e) begin bad++; $display("FAIL st_stall got=%0d exp=%0d", stall_o, e); end
    step; clear;
    look(0, 20, 21);
    sb.push_back(20); sb.push_back(21); sb.push_back(1);
    #1;
    e = sb.pop_front(); total++; if (rs1p(0) !== e) begin bad++; $display("FAIL st_hold20 got=%0d exp=%0d", rs1p(0), e); end
    e = sb.pop_front(); total++; if (rs2p(0) !== e) begin bad++; $display("FAIL st_hold21 got=%0d exp=%0d", rs2p(0), e); end
    e = sb.pop_front(); total++; if (32'(ckpt_free_o) !== e) begin bad++; $display("FAIL st_hold_free got=%0d exp=%0d", ckpt_free_o, e); end
    ckpt_release_i = 1;
    step; clear;
    set_slot(0, 0, 0, 20, 80, 1);
    set_slot(1, 0, 0, 21, 81, 1);
    sb.push_back(2); sb.push_back(0); sb.push_back(3); sb.push_back(0);
    #1;
    e = sb.pop_front(); total++; if (32'(ckpt_free_o) !== e) begin bad++; $display("FAIL st_rel_free got=%0d exp=%0d", ckpt_free_o, e); end
    e = sb.pop_front(); total++; if (32'(stall_o) !== e) begin bad++; $display("FAIL st_nostall got=%0d exp=%0d", stall_o, e); end
    e = sb.pop_front(); total++; if (cid(0) !== e) begin bad++; $display("FAIL st_id0 got=%0d exp=%0d", cid(0), e); end
    e = sb.pop_front(); total++; if (cid(1) !== e) begin bad++; $display("FAIL st_id1 got=%0d exp=%0d", cid(1), e); end
    step; clear;
    look(0, 20, 21);
    sb.push_back(80); sb.push_back(81); sb.push_back(0);
    #1;
    e = sb.pop_front(); total++; if (rs1p(0) !== e) begin bad++; $display("FAIL st_acc20 got=%0d exp=%0d", rs1p(0), e); end
    e = sb.pop_front(); total++; if (rs2p(0) !== e) begin bad++; $display("FAIL st_acc21 got=%0d exp=%0d", rs2p(0), e); end
    e = sb.pop_front(); total++; if (32'(ckpt_free_o) !== e) begin bad++; $display("FAIL st_acc_free got=%0d exp=%0d", ckpt_free_o, e); end
    // checkpoint 3 holds the map after slot 0 only
    recover_i = 1; recover_ckpt_i = 2'd3;
    step; clear;
    look(0, 20, 21);
    sb.push_back(80); sb.push_back(21); sb.push_back(2);
    #1;
    e = sb.pop_front(); total++; if (rs1p(0) !== e) begin bad++; $display("FAIL st_rec20 got=%0d exp=%0d", rs1p(0), e); end
    e = sb.pop_front(); total++; if (rs2p(0) !== e) begin bad++; $display("FAIL st_rec21 got=%0d exp=%0d", rs2p(0), e); end
    e = sb.pop_front(); total++; if (32'(ckpt_free_o) !== e) begin bad++; $display("FAIL st_rec_free got=%0d exp=%0d", ckpt_free_o, e); end
  endtask

  task automatic test_recover_release;
    int e;
    clear; rst_n = 0;
    step; rst_n = 1;
    for (int c = 0; c < 3; c++) begin
      set_slot(0, 0, 0, 12 + c, 90 + c, 1);
      step; clear;
    end
    recover_i = 1; recover_ckpt_i = 2'd1; ckpt_release_i = 1;
    step; clear;
    look(0, 13, 14);
    set_slot(1, 0, 0, 0, 0, 1);
    sb.push_back(91); sb.push_back(14); sb.push_back(4); sb.push_back(1);
    #1;
    e = sb.pop_front(); total++; if (rs1p(0) !== e) begin bad++; $display("FAIL rr_r13 got=%0d exp=%0d", rs1p(0), e); end
    e = sb.pop_front(); total++; if (rs2p(0) !== e) begin bad++; $display("FAIL rr_r14 got=%0d exp=%0d", rs2p(0), e); end
    e = sb.pop_front(); total++; if (32'(ckpt_free_o) !== e) begin bad++; $display("FAIL rr_free got=%0d exp=%0d", ckpt_free_o, e); end
    e = sb.pop_front(); total++; if (cid(1) !== e) begin bad++; $display("FAIL rr_tail got=%0d exp=%0d", cid(1), e); end
    step; clear;
    sb.push_back(3);
    #1;
    e = sb.pop_front(); total++; if (32'(ckpt_free_o) !== e) begin bad++; $display("FAIL rr_free3 got=%0d exp=%0d", ckpt_free_o, e); end
    ckpt_release_i = 1;
    step;
    sb.push_back(4);
    #1;
    e = sb.pop_front(); total++; if (32'(ckpt_free_o) !== e) begin bad++; $display("FAIL rr_rel got=%0d exp=%0d", ckpt_free_o, e); end
    step; clear;
    sb.push_back(4);
    #1;
    e = sb.pop_front(); total++; if (32'(ckpt_free_o) !== e) begin bad++; $display("FAIL rr_overrel got=%0d exp=%0d", ckpt_free_o, e); end
  endtask

  task automatic test_back_to_back;
    int e;
    step; clear;
    set_slot(0, 0, 0, 1, 100, 0);
    set_slot(1, 0, 0, 2, 101, 0);
    step; clear;
    set_slot(0, 1, 2, 1, 102, 0);
    set_slot(1, 0, 0, 0, 127, 0);
    sb.push_back(100); sb.push_back(101); sb.push_back(100); sb.push_back(0);
    #1;
    e = sb.pop_front(); total++; if (rs1p(0) !== e) begin bad++; $display("FAIL b2b_rs1 got=%0d exp=%0d", rs1p(0), e); end
    e = sb.pop_front(); total++; if (rs2p(0) !== e) begin bad++; $display("FAIL b2b_rs2 got=%0d exp=%0d", rs2p(0), e); end
    e = sb.pop_front(); total++; if (rdo(0) !== e) begin bad++; $display("FAIL b2b_rdold got=%0d exp=%0d", rdo(0), e); end
    e = sb.pop_front(); total++; if (rdo(1) !== e) begin bad++; $display("FAIL b2b_rd0old got=%0d exp=%0d", rdo(1), e); end
    step; clear;
    look(0, 1, 0);
    look(1, 0, 2);
    sb.push_back(102); sb.push_back(0); sb.push_back(101);
    #1;
    e = sb.pop_front(); total++; if (rs1p(0) !== e) begin bad++; $display("FAIL b2b_r1 got=%0d exp=%0d", rs1p(0), e); end
    e = sb.pop_front(); total++; if (rs2p(0) !== e) begin bad++; $display("FAIL b2b_r0 got=%0d exp=%0d", rs2p(0), e); end
    e = sb.pop_front(); total++; if (rs2p(1) !== e) begin bad++; $display("FAIL b2b_r2 got=%0d exp=%0d", rs2p(1), e); end
  endtask

  task automatic test_flush;
    int e;
    step; clear;
    cmt_valid_i = 2'b01; cmt_rd_i[AW-1:0] = AW'(4); cmt_phys_i[PW-1:0] = PW'(60);
    step; clear;
    set_slot(0, 0, 0, 4, 61, 1);
    step; clear;
    sb.push_back(3);
    #1;
    e = sb.pop_front(); total++; if (32'(ckpt_free_o) !== e) begin bad++; $display("FAIL fl_pre_free got=%0d exp=%0d", ckpt_free_o, e); end
    flush_i = 1;
    set_slot(0, 0, 0, 9, 90, 0);
    step; clear;
    look(0, 4, 9);
`ifdef RAT_MULTIPORT_COMMIT_RAT_EN
    sb.push_back(60);
`else
    sb.push_back(61);
`endif
    sb.push_back(9); sb.push_back(4);
    #1;
    e = sb.pop_front(); total++; if (rs1p(0) !== e) begin bad++; $display("FAIL fl_r4 got=%0d exp=%0d", rs1p(0), e); end
    e = sb.pop_front(); total++; if (rs2p(0) !== e) begin bad++; $display("FAIL fl_r9 got=%0d exp=%0d", rs2p(0), e); end
    e = sb.pop_front(); total++; if (32'(ckpt_free_o) !== e) begin bad++; $display("FAIL fl_free got=%0d exp=%0d", ckpt_free_o, e); end
  endtask

  initial begin
    test_reset;
    test_bypass;
    test_ckpt_recover;
    test_stall;
    test_recover_release;
    test_back_to_back;
    test_flush;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rat_multiport.md
RAT_MULTIPORT -- requirements
Module: rat_multiport

Interface
REQ-001 SHALL have parameter N_ARCH_REGS, default 32, architectural register count (reg 0 hardwired).
REQ-002 SHALL have parameter N_PHYS_REGS, default 128, physical register count; PW = $clog2(N_PHYS_REGS), AW = $clog2(N_ARCH_REGS).
REQ-003 SHALL have parameter RENAME_WIDTH, default 2, rename slots per cycle (RW); slot 0 is oldest.
REQ-004 SHALL have parameter N_CKPT, default 4, power-of-two checkpoint slots; CW = $clog2(N_CKPT).
REQ-005 SHALL have ports clk input 1 (single clock, rising edge) and rst_n input 1 (reset, asynchronous, active-low).
REQ-006 SHALL have ports flush_i input 1, recover_i input 1, recover_ckpt_i input CW (checkpoint to restore).
REQ-007 SHALL have ports ren_valid_i input RW, ren_rs1_i/ren_rs2_i/ren_rd_i input RW*AW, ren_new_phys_i input RW*PW, ren_ckpt_req_i input RW (slot is a branch).
REQ-008 SHALL have ports ren_rs1_phys_o/ren_rs2_phys_o/ren_rd_old_phys_o output RW*PW, ren_ckpt_id_o output RW*CW, stall_o output 1.
REQ-009 SHALL have ports ckpt_release_i input 1 (oldest branch resolved correct), ckpt_free_o output CW+1 (free slot count).
REQ-010 SHALL have ports cmt_valid_i input RW, cmt_rd_i input RW*AW, cmt_phys_i input RW*PW (retirement writes).

Function
REQ-011 Lookups SHALL be combinational: slot k sources/rd_old read RAT as updated by valid slots 0..k-1 with rd!=0 (youngest earlier writer wins).
REQ-012 Writes with rd==0 SHALL be ignored; RAT entry 0 SHALL always read 0.
REQ-013 Group accepted when ren_valid_i!=0, stall_o=0, recover_i=0, flush_i=0; on accept RAT SHALL take the state after all slots at next edge.
REQ-014 stall_o SHALL be combinationally 1 iff count of (ren_valid_i & ren_ckpt_req_i) > ckpt_free_o; stalled group SHALL cause no RAT or checkpoint change.
REQ-015 Checkpoints SHALL be a circular FIFO (head=oldest, tail=next free); requesting slots SHALL receive tail, tail+1, ... in slot order (mod N_CKPT) on ren_ckpt_id_o.
REQ-016 Checkpoint for slot k SHALL capture RAT state after slot k's own write, excluding slots k+1..RW-1.
REQ-017 ckpt_release_i SHALL pop head (head+1, free+1); release with free==N_CKPT SHALL be ignored.
REQ-018 recover_i SHALL load RAT from checkpoint recover_ckpt_i and set tail=recover_ckpt_i, freeing that slot and all younger.
REQ-019 Simultaneous recover_i and ckpt_release_i SHALL also pop head unless head==recover_ckpt_i (single free, no underflow).
REQ-020 Priority SHALL be reset > recover_i > flush_i > rename; rename ignored (no update) under recover or flush.
REQ-021 flush_i SHALL free all checkpoints (head=tail, free=N_CKPT); RAT behaviour per REQ-026.
REQ-022 A checkpoint taken and released/recovered in the same cycle SHALL not occur (recover blocks rename); outputs otherwise latency 0 combinational, state latency 1 cycle.

Reset
REQ-023 On rst_n low (asynchronous), RAT[i] SHALL be i, committed RAT[i] SHALL be i, head=tail=0, ckpt_free_o=N_CKPT, stall_o=0.
REQ-024 Checkpoint storage SHALL not require reset; free slots SHALL never be read.
REQ-025 Reset asserted mid-group SHALL discard the group; first post-reset lookup SHALL return identity map.

Configuration
REQ-026 Macro RAT_MULTIPORT_COMMIT_RAT_EN defined: committed RAT SHALL update from valid cmt_* slots (rd!=0, in slot order, every cycle incl. recover/flush) and flush_i SHALL load RAT from committed RAT (including same-cycle commits); undefined: cmt_* SHALL be ignored, no committed RAT storage, flush_i SHALL leave RAT unchanged.

Verification
REQ-027 Reset, lookup rs1=5 -> rs1_phys=5; ckpt_free_o=4, stall_o=0.
REQ-028 Slot0 rd=3 new=40, slot1 rs1=3 rd=3 new=41 -> slot1 rs1_phys=40, rd_old=40; next cycle lookup 3 -> 41.
REQ-029 Slot0 rd=7 new=50 ckpt_req, slot1 rd=7 new=51 -> ckpt_id 0; later recover_ckpt_i=0 -> lookup 7 = 50, ckpt_free_o=4.
REQ-030 3 checkpoints held, group requests 2 -> stall_o=1, RAT and free count unchanged; release then accepted -> ids 3,0.
REQ-031 Ckpts 0,1,2 held, recover_ckpt_i=1 with ckpt_release_i -> head=1, tail=1, ckpt_free_o=4.
REQ-032 With RAT_MULTIPORT_COMMIT_RAT_EN: commit rd=4 phys=60, rename rd=4 new=61, flush -> lookup 4 = 60; without macro -> 61.
